// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked
// serialisation of one command byte, then acknowledge check.
//
// Ports:
//   Fast_Clock, Reset       system clock, async active-high reset
//   Tx_Byte, Tx_Start       command byte and its one-cycle start strobe
//   KB_Clk_In, KB_Data_In   raw (asynchronous) PS/2 line levels
//   KB_Clk_OE, KB_Data_OE   1 = pull the line low, 0 = release it
//   Busy, Done              transfer in progress / one-cycle end pulse
//   Ack_Err, Timeout        sticky status, cleared by the next accepted start
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Fast_Clock,
  input  logic       Reset,
  input  logic [7:0] Tx_Byte,
  input  logic       Tx_Start,
  input  logic       KB_Clk_In,
  input  logic       KB_Data_In,
  output logic       KB_Clk_OE,
  output logic       KB_Data_OE,
  output logic       Busy,
  output logic       Done,
  output logic       Ack_Err,
  output logic       Timeout
);

  localparam int FW  = $clog2(FILTER_LEN) + 1;
  localparam int INW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int RQW = $clog2(REQ_CYCLES) + 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [FW-1:0]  FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [INW-1:0] INH_LAST  = INW'(INHIBIT_CYCLES - 1);
  localparam logic [RQW-1:0] REQ_LAST  = RQW'(REQ_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [TOW-1:0] TO_MAX    = TOW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          clk_filt_q, clk_filt_d;
  logic          data_filt_q, data_filt_d;
  logic [FW-1:0] clk_fcnt_q, clk_fcnt_d;
  logic [FW-1:0] data_fcnt_q, data_fcnt_d;
  logic          clk_prev_q;
  logic          fall;

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_fcnt_q  <= '0;
      data_fcnt_q <= '0;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], KB_Clk_In};
      data_sync_q <= {data_sync_q[0], KB_Data_In};
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_fcnt_q  <= clk_fcnt_d;
      data_fcnt_q <= data_fcnt_d;
      clk_prev_q  <= clk_filt_q;
    end
  end

  // A new level is accepted only after FILTER_LEN consecutive
  // synchronized samples disagree with the current filtered level.
  always_comb begin
    clk_filt_d  = clk_filt_q;
    clk_fcnt_d  = '0;
    data_filt_d = data_filt_q;
    data_fcnt_d = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_fcnt_q >= FILT_LAST) begin
        clk_filt_d = clk_sync_q[1];
      end else begin
        clk_fcnt_d = clk_fcnt_q + FW'(1);
      end
    end
    if (data_sync_q[1] != data_filt_q) begin
      if (data_fcnt_q >= FILT_LAST) begin
        data_filt_d = data_sync_q[1];
      end else begin
        data_fcnt_d = data_fcnt_q + FW'(1);
      end
    end
  end

  assign fall = clk_prev_q & ~clk_filt_q;

  // ---------------- transfer FSM ----------------
  state_t         state_q, state_d;
  logic [9:0]     frame_q, frame_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [INW-1:0] inh_cnt_q, inh_cnt_d;
  logic [RQW-1:0] req_cnt_q, req_cnt_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           data_oe_q, data_oe_d;
  logic           ack_err_q, ack_err_d;
  logic           timeout_q, timeout_d;
  logic           to_run;
  logic           to_hit;

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      req_cnt_q <= '0;
      to_cnt_q  <= '0;
      data_oe_q <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      req_cnt_q <= req_cnt_d;
      to_cnt_q  <= to_cnt_d;
      data_oe_q <= data_oe_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign to_run = (state_q == S_DATA) |
                  (state_q == S_ACK) |
                  (state_q == S_WAIT_IDLE);
  assign to_hit = to_run & (to_cnt_q >= TO_LAST);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    req_cnt_d = req_cnt_q;
    to_cnt_d  = to_cnt_q;
    data_oe_d = data_oe_q;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;

    if (to_run) begin
      if (fall) begin
        to_cnt_d = '0;
      end else if (to_cnt_q < TO_MAX) begin
        to_cnt_d = to_cnt_q + TOW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (Tx_Start) begin
          frame_d   = {1'b1, ~^Tx_Byte, Tx_Byte};
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q >= INH_LAST) begin
          // Start bit goes low together with entering REQ.
          req_cnt_d = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INW'(1);
        end
      end
      S_REQ: begin
        if (req_cnt_q >= REQ_LAST) begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = S_DATA;
        end else begin
          req_cnt_d = req_cnt_q + RQW'(1);
        end
      end
      S_DATA: begin
        if (to_hit) begin
          timeout_d = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_DONE;
        end else if (fall) begin
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b0, frame_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (to_hit) begin
          timeout_d = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_DONE;
        end else if (fall) begin
          ack_err_d = data_filt_q;
          state_d   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (to_hit) begin
          timeout_d = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_DONE;
        end else if (clk_filt_q & data_filt_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Data drive is gated by state so that leaving DATA releases the
  // line regardless of the last bit presented.
  assign KB_Clk_OE  = (state_q == S_INHIBIT) | (state_q == S_REQ);
  assign KB_Data_OE = data_oe_q &
                      ((state_q == S_REQ) | (state_q == S_DATA));
  assign Busy       = (state_q != S_IDLE);
  assign Done       = (state_q == S_DONE);
  assign Ack_Err    = ack_err_q;
  assign Timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: behavioural PS/2 device on open-drain lines,
// expected frames computed from the byte value.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int REQ  = 4;
  localparam int TO   = 300;
  localparam int FL   = 2;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       dev_clk;
  logic       dev_data;
  logic       line_clk;
  logic       line_data;
  logic       clk_oe;
  logic       data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  assign line_clk  = dev_clk & ~clk_oe;
  assign line_data = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES(REQ),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .Fast_Clock(clk),
    .Reset(rst),
    .Tx_Byte(tx_byte),
    .Tx_Start(tx_start),
    .KB_Clk_In(line_clk),
    .KB_Data_In(line_data),
    .KB_Clk_OE(clk_oe),
    .KB_Data_OE(data_oe),
    .Busy(busy),
    .Done(done),
    .Ack_Err(ack_err),
    .Timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: D0..D7, odd parity, stop bit, in wire order.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2) == 0;
    return {1'b1, p, b};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_byte  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device side: waits for request-to-send, clocks nclk bits reading
  // on rising edges, then (for a full frame) gives the ack clock.
  task automatic dev_frame(
    input  int         nclk,
    input  bit         ack,
    input  bit         inject,
    output logic [9:0] bits,
    output int         hold_bad,
    output bit         rts_ok,
    output int         t_fall
  );
    int n;
    bits     = '0;
    hold_bad = 0;
    t_fall   = cyc;
    n        = 0;
    while (!(!clk_oe && data_oe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    rts_ok = (n < 200);
    if (!rts_ok) return;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      dev_clk = 1'b0;
      t_fall  = cyc;
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (inject && i == 3 && k == 5) begin
          tx_byte  = 8'h55;
          tx_start = 1'b1;
        end else begin
          tx_start = 1'b0;
        end
      end
      dev_clk = 1'b1;
      bits[i] = line_data;
      repeat (HALF) @(negedge clk);
      if (line_data !== bits[i]) hold_bad++;
    end
    if (nclk == 10) begin
      dev_data = ~ack;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int d0, output bit seen);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    seen = (done_cnt != d0);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    tx_byte  = 8'h00;
    tx_start = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({clk_oe, data_oe, busy, done, ack_err, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {clk_oe, data_oe, busy, done, ack_err, timeout});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_basic;
    int d0, inh, req, n, hb, tf;
    logic [9:0] bits;
    bit ok, seen;
    d0 = done_cnt;
    start_tx(8'hED);
    checks++;
    if (clk_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: clk_oe=%b busy=%b want 1 1",
               clk_oe, busy);
    end
    inh = 0;
    req = 0;
    n   = 0;
    while (clk_oe && n < 100) begin
      if (data_oe) req++;
      else inh++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (inh != INH) begin
      errors++;
      $display("FAIL inhibit_len: got %0d want %0d", inh, INH);
    end
    checks++;
    if (req != REQ) begin
      errors++;
      $display("FAIL req_len: got %0d want %0d", req, REQ);
    end
    dev_frame(10, 1'b1, 1'b0, bits, hb, ok, tf);
    wait_done(d0, seen);
    checks++;
    if (!ok || bits !== exp_frame(8'hED)) begin
      errors++;
      $display("FAIL basic_bits: got %b want %b rts=%0d",
               bits, exp_frame(8'hED), ok);
    end
    checks++;
    if (hb != 0) begin
      errors++;
      $display("FAIL basic_hold: got %0d changes want 0", hb);
    end
    checks++;
    if (done_cnt - d0 != 1 || !seen) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
    end
    checks++;
    if ({ack_err, timeout, busy} !== 3'b000) begin
      errors++;
      $display("FAIL basic_status: got %b want 000",
               {ack_err, timeout, busy});
    end
  endtask

  task automatic test_parity;
    logic [7:0] list [6];
    logic [9:0] bits;
    int d0, hb, tf;
    bit ok, seen;
    list[0] = 8'h01;
    list[1] = 8'h00;
    for (int j = 2; j < 6; j++) list[j] = 8'($urandom);
    for (int j = 0; j < 6; j++) begin
      d0 = done_cnt;
      start_tx(list[j]);
      dev_frame(10, 1'b1, 1'b0, bits, hb, ok, tf);
      wait_done(d0, seen);
      checks++;
      if (!ok || !seen || bits !== exp_frame(list[j])) begin
        errors++;
        $display("FAIL frame_%02h: got %b want %b done=%0d",
                 list[j], bits, exp_frame(list[j]), seen);
      end
      checks++;
      if (ack_err !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL status_%02h: ack_err=%b timeout=%b want 0 0",
                 list[j], ack_err, timeout);
      end
    end
  endtask

  task automatic test_nack;
    logic [7:0] b;
    logic [9:0] bits;
    int d0, hb, tf;
    bit ok, seen;
    b  = 8'($urandom);
    d0 = done_cnt;
    start_tx(b);
    dev_frame(10, 1'b0, 1'b0, bits, hb, ok, tf);
    wait_done(d0, seen);
    checks++;
    if (ack_err !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL nack_status: ack_err=%b timeout=%b want 1 0",
               ack_err, timeout);
    end
    checks++;
    if (done_cnt - d0 != 1 || bits !== exp_frame(b)) begin
      errors++;
      $display("FAIL nack_frame: pulses=%0d bits=%b want 1 %b",
               done_cnt - d0, bits, exp_frame(b));
    end
    b  = 8'($urandom);
    d0 = done_cnt;
    start_tx(b);
    checks++;
    if (ack_err !== 1'b0) begin
      errors++;
      $display("FAIL nack_clear: ack_err=%b want 0", ack_err);
    end
    dev_frame(10, 1'b1, 1'b0, bits, hb, ok, tf);
    wait_done(d0, seen);
    checks++;
    if (!seen || ack_err !== 1'b0 || bits !== exp_frame(b)) begin
      errors++;
      $display("FAIL after_nack: ack_err=%b bits=%b want 0 %b",
               ack_err, bits, exp_frame(b));
    end
  endtask

  task automatic test_timeout;
    logic [9:0] bits;
    int d0, hb, tf, n, delta;
    bit ok;
    logic prev_doe;
    d0 = done_cnt;
    start_tx(8'hE5);
    dev_frame(4, 1'b1, 1'b0, bits, hb, ok, tf);
    n        = 0;
    prev_doe = data_oe;
    while (!timeout && n < 400) begin
      prev_doe = data_oe;
      @(negedge clk);
      n++;
    end
    delta = cyc - tf;
    checks++;
    if (timeout !== 1'b1 || delta < TO || delta > TO + 15) begin
      errors++;
      $display("FAIL timeout_time: timeout=%b after %0d cycles want %0d..%0d",
               timeout, delta, TO, TO + 15);
    end
    checks++;
    if (prev_doe !== 1'b1 || {clk_oe, data_oe, done} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_release: prev_doe=%b clk_oe,data_oe,done=%b want 1 001",
               prev_doe, {clk_oe, data_oe, done});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt - d0 != 1 || ack_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_end: busy=%b pulses=%0d ack_err=%b want 0 1 0",
               busy, done_cnt - d0, ack_err);
    end
  endtask

  task automatic test_ignore_start;
    logic [9:0] bits;
    int d0, hb, tf;
    bit ok, seen;
    d0 = done_cnt;
    start_tx(8'hED);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: timeout=%b want 0", timeout);
    end
    dev_frame(10, 1'b1, 1'b1, bits, hb, ok, tf);
    wait_done(d0, seen);
    checks++;
    if (!ok || bits !== exp_frame(8'hED)) begin
      errors++;
      $display("FAIL ignore_bits: got %b want %b",
               bits, exp_frame(8'hED));
    end
    repeat (60) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignore_idle: busy=%b pulses=%0d want 0 1",
               busy, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    int d0, hb, tf;
    bit ok, seen;
    start_tx(8'hED);
    dev_frame(2, 1'b1, 1'b0, bits, hb, ok, tf);
    checks++;
    if (data_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: data_oe=%b busy=%b want 1 1", data_oe, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({clk_oe, data_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL mid_async: clk_oe,data_oe,busy=%b want 000",
               {clk_oe, data_oe, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    start_tx(8'hFF);
    dev_frame(10, 1'b1, 1'b0, bits, hb, ok, tf);
    wait_done(d0, seen);
    checks++;
    if (!ok || !seen || bits !== exp_frame(8'hFF)) begin
      errors++;
      $display("FAIL post_reset_ff: bits=%b want %b done=%0d",
               bits, exp_frame(8'hFF), seen);
    end
    checks++;
    if ({ack_err, timeout, busy} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_status: got %b want 000",
               {ack_err, timeout, busy});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_nack();
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter that sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It runs the host side of the PS/2 bidirectional protocol: clock inhibit, request-to-send, device-clocked serialisation, then acknowledge check. It drives the keyboard clock and data lines open-drain through output-enable ports and sits beside the existing PS2 receiver on the same pair of lines. IO_Module issues the byte and a start strobe and reads back the status.

Parameters:
INHIBIT_CYCLES, 5000, Fast_Clock cycles the clock line is held low (100 µs at 50 MHz).
REQ_CYCLES, 50, cycles with both clock and data held low before the clock is released.
TIMEOUT_CYCLES, 750000, maximum cycles without a device falling edge (15 ms) before abort.
FILTER_LEN, 8, consecutive equal synchronized samples needed to accept a new line level.

Ports:
Fast_Clock  input  1  system clock; all logic on rising edge.
Reset  input  1  asynchronous, active-high reset.
Tx_Byte  input  8  command byte; sampled only in the cycle Tx_Start is high while idle.
Tx_Start  input  1  single-cycle request to transmit.
KB_Clk_In  input  1  raw PS/2 clock line level (asynchronous).
KB_Data_In  input  1  raw PS/2 data line level (asynchronous).
KB_Clk_OE  output  1  1 = pull the clock line low; 0 = release it.
KB_Data_OE  output  1  1 = pull the data line low; 0 = release it.
Busy  output  1  high from the cycle after an accepted Tx_Start until the Done cycle (inclusive).
Done  output  1  one-cycle pulse when a transfer ends, whether it succeeded or failed.
Ack_Err  output  1  device did not acknowledge; held until the next accepted Tx_Start.
Timeout  output  1  transfer aborted on timeout; held until the next accepted Tx_Start.

Behaviour:
- Reset, asynchronous: all outputs go to 0, which releases both lines immediately. State goes to IDLE. Filtered line levels go to 1. This applies even mid-transfer; no partial frame resumes afterwards.
- Input conditioning:
  - Two-flop synchronizer on each line, then a FILTER_LEN agreement filter.
  - Fall = filtered clock was 1 in the previous cycle and is 0 now.
- Frame register: 10 bits, {stop=1, parity, Tx_Byte}, shifted LSB first. Parity is odd: parity = ~^Tx_Byte.
- IDLE:
  - OE outputs are 0 and Busy is 0.
  - Tx_Start latches the frame, clears Ack_Err and Timeout, and moves to INHIBIT.
  - Tx_Start is ignored in every state other than IDLE.
- INHIBIT: KB_Clk_OE=1 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ:
  - KB_Clk_OE=1 and KB_Data_OE=1 (start bit) for REQ_CYCLES cycles.
  - Then KB_Clk_OE=0 and go to DATA with bit count 0 and the timeout counter cleared.
- DATA:
  - On each Fall, KB_Data_OE = ~frame[0], then shift right and increment the count.
  - Falls 1-8 present data bits D0..D7, fall 9 presents parity, and fall 10 presents the stop bit (line released).
  - After fall 10, go to ACK.
- ACK:
  - On the next Fall, sample the filtered data.
  - 0 means acknowledged; 1 sets Ack_Err.
  - Go to WAIT_IDLE.
- WAIT_IDLE: when filtered clock=1 and data=1, go to DONE.
- DONE: Done=1 for one cycle, then IDLE.
- Timeout:
  - In DATA, ACK and WAIT_IDLE the counter increments every cycle and clears on every Fall.
  - When it reaches TIMEOUT_CYCLES: set Timeout, release both lines the same cycle, go to DONE.
  - If Timeout coincides with a Fall in ACK, Timeout wins and Ack_Err is not updated.
- Line-state rules:
  - KB_Data_OE never changes while the filtered clock is high during DATA.
  - KB_Clk_OE is 1 only in INHIBIT and REQ.
- Counter widths: each counter is sized to its parameter (ceil log2 + 1) and saturates; no wrap-around.
- Latency: an accepted Tx_Start drives KB_Clk_OE=1 on the next cycle.

Test Plan (bench parameters INHIBIT_CYCLES=20, REQ_CYCLES=4, TIMEOUT_CYCLES=300, FILTER_LEN=2; device model toggles clock with a 40-cycle period):
- Send 0xED, device acks -> KB_Clk_OE high 20 cycles, then both OE high 4 cycles; bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1; Done pulses once; Ack_Err=0, Timeout=0.
- Send 0x01 and 0x00 -> parity bit 0 for 0x01 and 1 for 0x00; the 8 data bits match LSB-first.
- Device leaves data high at the ack clock -> Ack_Err=1, Done pulses, Timeout=0; Ack_Err is cleared by the next Tx_Start.
- Device stops clocking after 4 bits -> 300 cycles later Timeout=1, both OE=0 the same cycle, Done pulses, Busy falls.
- Tx_Start reasserted mid-frame with 0x55 -> ignored; the frame in progress stays 0xED.
- Reset asserted during DATA -> both OE and Busy go to 0 asynchronously; a following 0xFF transmits a full, correct frame.
